fmul_rr_arbiter: RTL

- Shares one pipelined single-precision multiplier (`mul`) among N_REQ requesters, for example DCT row/column butterflies.
- Round-robin issue: at most one operation enters the multiplier per cycle.
- A latency-matched tag pipeline tracks which requester owns each in-flight operation and steers the product back to it.
- Results are returned as single-cycle pulses carrying the requester ID.

---
 rtl/fmul_rr_arbiter.sv | 90 +++++++++
 1 files changed

// File: rtl/fmul_rr_arbiter.sv
// rtl/fmul_rr_arbiter.sv - round-robin sharing of one pipelined single-precision multiplier
// A tag pipeline, latency-matched to the multiplier, steers each product back to its requester.
module fmul_rr_arbiter #(
   parameter int N_REQ   = 4,
   parameter int ID_W    = 2,
   parameter int LATENCY = 7
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 hold,
   input  logic [N_REQ-1:0]     req_valid,
   input  logic [32*N_REQ-1:0]  req_a,
   input  logic [32*N_REQ-1:0]  req_b,
   output logic [N_REQ-1:0]     req_ready,
   output logic                 mul_stt,
   output logic [31:0]          mul_a,
   output logic [31:0]          mul_b,
   input  logic [31:0]          mul_z,
   output logic                 rsp_valid,
   output logic [ID_W-1:0]      rsp_id,
   output logic [31:0]          rsp_data,
   output logic [3:0]           inflight,
   output logic                 busy
);

   logic [ID_W-1:0] last_gnt;
   logic [ID_W-1:0] gnt_id;
   logic [ID_W-1:0] cand;
   logic            gnt_any;

   // Stage 0 is written alongside mul_stt; stage LATENCY lines up with a valid mul_z.
   logic [LATENCY:0] tag_valid;
   logic [ID_W-1:0]  tag_id [0:LATENCY];

   always_comb begin
      gnt_any = 1'b0;
      gnt_id  = '0;
      cand    = '0;
      if (!hold) begin
         for (int k = 1; k <= N_REQ; k++) begin
            cand = ID_W'((int'(last_gnt) + k) % N_REQ);
            if (!gnt_any && req_valid[cand]) begin
               gnt_any = 1'b1;
               gnt_id  = cand;
            end
         end
      end
   end

   assign req_ready = gnt_any ? (N_REQ'(1) << gnt_id) : '0;
   assign busy      = mul_stt || (inflight != 4'd0);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mul_stt   <= 1'b0;
         mul_a     <= '0;
         mul_b     <= '0;
         last_gnt  <= ID_W'(N_REQ - 1);
         tag_valid <= '0;
         for (int s = 0; s <= LATENCY; s++) begin
            tag_id[s] <= '0;
         end
         rsp_valid <= 1'b0;
         rsp_id    <= '0;
         rsp_data  <= '0;
         inflight  <= '0;
      end else begin
         mul_stt <= gnt_any;
         if (gnt_any) begin
            mul_a    <= req_a[32*int'(gnt_id) +: 32];
            mul_b    <= req_b[32*int'(gnt_id) +: 32];
            last_gnt <= gnt_id;
         end
         tag_valid <= {tag_valid[LATENCY-1:0], gnt_any};
         tag_id[0] <= gnt_id;
         for (int s = LATENCY; s > 0; s--) begin
            tag_id[s] <= tag_id[s-1];
         end
         rsp_valid <= tag_valid[LATENCY];
         rsp_id    <= tag_id[LATENCY];
         rsp_data  <= mul_z;
         case ({gnt_any, tag_valid[LATENCY]})
            2'b10:   inflight <= inflight + 4'd1;
            2'b01:   inflight <= inflight - 4'd1;
            default: inflight <= inflight;
         endcase
      end
   end

endmodule
